// File: rtl/led_fader.sv
// Triangle-wave LED fader: ramps a brightness level up, holds, ramps down, and
// publishes per-channel shifted compare values to pwm units on each pwm_sync.
module led_fader #(
    parameter int CTR_LEN    = 8,
    parameter int CH         = 8,
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_TICKS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  pwm_sync,
    output logic [CH*CTR_LEN-1:0] compare,
    output logic                  compare_valid,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RISE = 2'b01,
        HOLD = 2'b10,
        FALL = 2'b11
    } state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PW-1:0] PS_LAST   = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    state_t               cur, nxt;
    logic [PW-1:0]        ps_q, ps_d;
    logic                 tick;
    logic [CTR_LEN-1:0]   lvl_q, lvl_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [CH*CTR_LEN-1:0] shadow;

    // Prescaler parks at 0 in IDLE so the first tick lands TICK_DIV cycles later.
    always_comb begin
        tick = (cur != IDLE) && (ps_q == PS_LAST);
        ps_d = (cur == IDLE || tick) ? '0 : ps_q + 1'b1;
    end

    always_comb begin
        nxt    = cur;
        lvl_d  = lvl_q;
        hold_d = hold_q;
        case (cur)
            IDLE: begin
                lvl_d = '0;
                if (en) nxt = RISE;
            end
            RISE: begin
                if (!en) begin
                    nxt = FALL;
                end else if (tick) begin
                    lvl_d = lvl_q + 1'b1;
                    if (&lvl_d) begin
                        nxt    = HOLD;
                        hold_d = '0;
                    end
                end
            end
            HOLD: begin
                if (!en) begin
                    nxt = FALL;
                end else if (tick) begin
                    if (hold_q == HOLD_LAST) nxt = FALL;
                    else hold_d = hold_q + 1'b1;
                end
            end
            FALL: begin
                // en is deliberately ignored here: a fade-out always completes.
                if (tick) begin
                    if (lvl_q <= CTR_LEN'(1)) begin
                        lvl_d = '0;
                        nxt   = en ? RISE : IDLE;
                    end else begin
                        lvl_d = lvl_q - 1'b1;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= IDLE;
            ps_q   <= '0;
            lvl_q  <= '0;
            hold_q <= '0;
        end else begin
            cur    <= nxt;
            ps_q   <= ps_d;
            lvl_q  <= lvl_d;
            hold_q <= hold_d;
        end
    end

    assign state = cur;

    genvar i;
    generate
        for (i = 0; i < CH; i++) begin : g_shadow
            if (i < CTR_LEN) begin : g_live
                assign shadow[i*CTR_LEN +: CTR_LEN] = lvl_q >> i;
            end else begin : g_zero
                assign shadow[i*CTR_LEN +: CTR_LEN] = '0;
            end
        end
    endgenerate

    // Publishing samples the pre-edge level, so a coincident tick shows up one sync later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            compare       <= '0;
            compare_valid <= 1'b0;
        end else begin
            if (pwm_sync) compare <= shadow;
            compare_valid <= pwm_sync;
        end
    end

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: directed scenarios plus random traffic, all checked every
// cycle against an integer-arithmetic model of the fade cycle.
module tb_led_fader;

    localparam int CL = 3;
    localparam int CH = 4;
    localparam int TD = 4;
    localparam int HT = 2;
    localparam int MAXL = (1 << CL) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              pwm_sync;
    logic [CH*CL-1:0]  compare;
    logic              compare_valid;
    logic [1:0]        state;

    int tests = 0;
    int fails = 0;

    // Reference model (plain integers, updated once per clock edge)
    int m_st, m_lvl, m_ps, m_hold;
    int m_cmp [CH];
    bit m_vld;

    led_fader #(.CTR_LEN(CL), .CH(CH), .TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pwm_sync     (pwm_sync),
        .compare      (compare),
        .compare_valid(compare_valid),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_lvl = 0; m_ps = 0; m_hold = 0; m_vld = 0;
        for (int i = 0; i < CH; i++) m_cmp[i] = 0;
    endtask

    task automatic model_step(input bit e, input bit s);
        bit tk;
        if (s) for (int i = 0; i < CH; i++) m_cmp[i] = (i < CL) ? m_lvl / (2 ** i) : 0;
        m_vld = s;
        tk = (m_st != 0) && (m_ps == TD - 1);
        m_ps = (m_st == 0) ? 0 : (m_ps + 1) % TD;
        case (m_st)
            0: if (e) m_st = 1;
            1: if (!e) m_st = 3;
               else if (tk) begin
                   m_lvl++;
                   if (m_lvl == MAXL) begin m_st = 2; m_hold = 0; end
               end
            2: if (!e) m_st = 3;
               else if (tk) begin
                   m_hold++;
                   if (m_hold == HT) m_st = 3;
               end
            default: if (tk) begin
                   if (m_lvl > 0) m_lvl--;
                   if (m_lvl == 0) m_st = e ? 1 : 0;
               end
        endcase
    endtask

    function automatic logic [CH*CL-1:0] exp_cmp();
        logic [CH*CL-1:0] r;
        for (int i = 0; i < CH; i++) r[i*CL +: CL] = CL'(m_cmp[i]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_state"}, 64'(state), 64'(m_st));
        check({tag, "_compare"}, 64'(compare), 64'(exp_cmp()));
        check({tag, "_valid"}, 64'(compare_valid), 64'(m_vld));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step(en, pwm_sync);
        #1;
        check_model(tag);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_async_state"}, 64'(state), 64'd0);
        check({tag, "_async_compare"}, 64'(compare), 64'd0);
        check({tag, "_async_valid"}, 64'(compare_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic timeout(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: observed timeout expected condition reached", tag);
    endtask

    initial begin
        int hold_cyc, idle_seen, k;
        bit seen5;
        rst_n = 1'b0; en = 1'b0; pwm_sync = 1'b0;
        model_reset();
        #1;
        check("reset_state", 64'(state), 64'd0);
        check("reset_compare", 64'(compare), 64'd0);
        check("reset_valid", 64'(compare_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full cycle with sync every cycle
        en = 1'b1; pwm_sync = 1'b1;
        hold_cyc = 0; idle_seen = 0; seen5 = 0;
        for (int c = 0; c < 70; c++) begin
            cyc("full");
            if (state == 2'b10) hold_cyc++;
            if (state == 2'b00) idle_seen++;
            if (!seen5 && m_cmp[0] == 5) begin
                seen5 = 1;
                check("full_lvl5_compare", 64'(compare), 64'h055);
            end
        end
        check("full_hold_cycles", 64'(hold_cyc), 64'd8);
        check("full_no_idle", 64'(idle_seen), 64'd0);
        check("full_rise_again", 64'(state), 64'd1);

        // Publish gating: no sync, then a single pulse at lvl=3
        do_reset("gate");
        en = 1'b1; pwm_sync = 1'b0;
        for (k = 0; k < 100 && m_lvl != 3; k++) cyc("gate");
        if (m_lvl != 3) timeout("gate_lvl3");
        check("gate_compare_zero", 64'(compare), 64'd0);
        pwm_sync = 1'b1;
        cyc("gate_pulse");
        check("gate_pulse_compare", 64'(compare), 64'h00B);
        check("gate_pulse_valid", 64'(compare_valid), 64'd1);
        pwm_sync = 1'b0;
        cyc("gate_after");
        check("gate_after_valid", 64'(compare_valid), 64'd0);
        check("gate_after_hold", 64'(compare), 64'h00B);

        // Fade-out: drop en during HOLD
        for (k = 0; k < 200 && m_st != 2; k++) cyc("fade");
        if (m_st != 2) timeout("fade_hold");
        cyc("fade");
        en = 1'b0;
        cyc("fade_drop");
        check("fade_to_fall", 64'(state), 64'd3);
        for (k = 0; k < 200 && m_st != 0; k++) cyc("fade_fall");
        if (m_st != 0) timeout("fade_idle");
        pwm_sync = 1'b1;
        cyc("fade_pub");
        check("fade_state_idle", 64'(state), 64'd0);
        check("fade_compare_zero", 64'(compare), 64'd0);

        // Collision of tick and sync at lvl 2->3
        do_reset("coll");
        en = 1'b1; pwm_sync = 1'b0;
        for (k = 0; k < 100 && !(m_st == 1 && m_lvl == 2 && m_ps == TD - 1); k++) cyc("coll");
        if (m_lvl != 2) timeout("coll_lvl2");
        pwm_sync = 1'b1;
        cyc("coll_edge");
        check("coll_pre_tick", 64'(compare[CL-1:0]), 64'd2);
        pwm_sync = 1'b0;
        cyc("coll_wait");
        pwm_sync = 1'b1;
        cyc("coll_next");
        check("coll_post_tick", 64'(compare[CL-1:0]), 64'd3);

        // Async reset mid-RISE at lvl=4
        for (k = 0; k < 100 && m_lvl != 4; k++) cyc("arst");
        if (m_lvl != 4) timeout("arst_lvl4");
        check("arst_pre_compare_nonzero", 64'(compare != '0), 64'd1);
        do_reset("arst");
        en = 1'b0; pwm_sync = 1'b0;

        // IDLE with en=0 for 100 cycles, then the first tick timing
        for (int c = 0; c < 100; c++) cyc("idle");
        en = 1'b1; pwm_sync = 1'b1;
        for (int c = 0; c < 6; c++) cyc("idle_leave");

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 15) != 0);
            pwm_sync = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) do_reset("rand_rst");
            else cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
